// File: rtl/hpdcache_sram_rd_buf_pkg.sv
// Shared request type and size defaults for the SRAM read buffer slice.
package hpdcache_sram_rd_buf_pkg;

  localparam int ADDR_SIZE_DEFAULT = 6;
  localparam int DATA_SIZE_DEFAULT = 64;
  localparam int RSP_DEPTH_DEFAULT = 3;

  typedef struct packed {
    logic                         we;
    logic [ADDR_SIZE_DEFAULT-1:0] addr;
    logic [DATA_SIZE_DEFAULT-1:0] wdata;
    logic [DATA_SIZE_DEFAULT-1:0] wmask;
  } req_t;

endpackage

// File: rtl/hpdcache_sram_rsp_fifo.sv
// Small synchronous FIFO holding SRAM read responses; head is read straight from the storage registers.
module hpdcache_sram_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (do_push & ~do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop & ~do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hpdcache_sram_rd_buf.sv
// SRAM front-end: forwards requests to a 1-cycle-latency SRAM and buffers read data until consumed.
// Define HPDCACHE_SRAM_RD_BUF_BYPASS_EN to forward read data in the SRAM output cycle when the buffer is empty.
module hpdcache_sram_rd_buf
  import hpdcache_sram_rd_buf_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT,
  parameter int DATA_SIZE = DATA_SIZE_DEFAULT,
  parameter int RSP_DEPTH = RSP_DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  input  logic [DATA_SIZE-1:0] req_wmask,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [ADDR_SIZE-1:0] sram_addr,
  output logic [DATA_SIZE-1:0] sram_wdata,
  output logic [DATA_SIZE-1:0] sram_wmask,
  input  logic [DATA_SIZE-1:0] sram_rdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_SIZE-1:0] rsp_rdata
);

  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(RSP_DEPTH);

  logic                 inflight;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [DATA_SIZE-1:0] fifo_rdata;
  logic [CW:0]          credit_used;

  // Credit counts the read in the SRAM pipe too, so a popped slot only frees credit next cycle.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign req_ready   = ~rst & ~fifo_full & (credit_used < DEPTH_C);

  assign sram_cs    = req_valid & req_ready;
  assign sram_we    = req_we;
  assign sram_addr  = req_addr;
  assign sram_wdata = req_wdata;
  assign sram_wmask = req_wmask;

  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= sram_cs & ~req_we;
  end

`ifdef HPDCACHE_SRAM_RD_BUF_BYPASS_EN
  assign rsp_valid = ~rst & (~fifo_empty | inflight);
  assign rsp_rdata = fifo_empty ? sram_rdata : fifo_rdata;
  assign fifo_push = ~rst & inflight & ~(fifo_empty & rsp_ready);
`else
  assign rsp_valid = ~rst & ~fifo_empty;
  assign rsp_rdata = fifo_rdata;
  assign fifo_push = ~rst & inflight;
`endif

  assign fifo_pop = ~rst & ~fifo_empty & rsp_ready;

  hpdcache_sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_SIZE)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (sram_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
